// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word layout, field positions and sequencer state encoding
// for the microprogrammed controller that drives the cpu mir input.
package cpu_ctrl_pkg;

   localparam int CW_W  = 40;
   localparam int MIR_W = 28;

   // Control-word sequencing fields, above the mir image
   localparam int NA_W     = 9;
   localparam int NA_LSB   = 31;
   localparam int JMPC_BIT = 30;
   localparam int JAMN_BIT = 29;
   localparam int JAMZ_BIT = 28;

   localparam int SHIFT_LSB = 26;
   localparam int SHIFT_W   = 2;
   localparam int ALU_LSB   = 20;
   localparam int ALU_W     = 6;
   localparam int MEMWR_BIT = 19;
   localparam int MEMRD_BIT = 18;
   localparam int RAMA_LSB  = 14;
   localparam int RAMA_W    = 4;
   localparam int CBUS_LSB  = 4;
   localparam int CBUS_W    = 10;
   localparam int BSEL_LSB  = 0;
   localparam int BSEL_W    = 4;

   localparam logic [NA_W-1:0] HALT_ADDR_DEF = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      EXEC,
      DONE
   } state_t;

   // Words that read memory or write any register need the extra hold time.
   function automatic logic is_long(input logic [MIR_W-1:0] m);
      return m[MEMRD_BIT] | (|m[CBUS_LSB +: CBUS_W]);
   endfunction

endpackage

// File: rtl/control_store.sv
// Control-store RAM: single write port, registered read port that only
// updates when a read is requested so the fetched word stays put.
module control_store
   import cpu_ctrl_pkg::*;
#(
   parameter int ADDR_W = 9
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [CW_W-1:0]   wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [CW_W-1:0]   rdata
);

   logic [CW_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fetches control words, stretches each one over the
// datapath latency and branches on jam/JMPC fields. MICRO_SEQ_STEP_EN adds a
// single-step input that gates the advance out of every microinstruction.
module micro_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int                ADDR_W     = 9,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(HALT_ADDR_DEF),
   parameter int                LONG_WAIT  = 1
) (
`ifdef MICRO_SEQ_STEP_EN
   input  logic              step,
`endif
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              flag_n,
   input  logic              flag_z,
   input  logic [7:0]        mbr_byte,
   input  logic              cs_we,
   input  logic [ADDR_W-1:0] cs_waddr,
   input  logic [CW_W-1:0]   cs_wdata,
   output logic [MIR_W-1:0]  mir,
   output logic [ADDR_W-1:0] mpc,
   output logic              busy,
   output logic              done
);

   localparam int HOLD_W = $clog2(LONG_WAIT + 1) + 1;

   state_t            state;
   state_t            state_nx;
   logic [CW_W-1:0]   word;
   logic              cs_re;
   logic              cs_wen;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_last;
   logic              hold_done;
   logic              advance;
   logic [NA_W-1:0]   next_raw;
   logic [ADDR_W-1:0] next_addr;
   logic              is_halt;
   logic              idle_like;

   assign idle_like = (state == IDLE) || (state == DONE);
   assign cs_wen    = cs_we & idle_like;

   control_store #(
      .ADDR_W(ADDR_W)
   ) u_store (
      .clock(clock),
      .we   (cs_wen),
      .waddr(cs_waddr),
      .wdata(cs_wdata),
      .re   (cs_re),
      .raddr(mpc),
      .rdata(word)
   );

   assign hold_last = is_long(word[MIR_W-1:0]) ? HOLD_W'(LONG_WAIT) : '0;
   assign hold_done = (hold_cnt == hold_last);

`ifdef MICRO_SEQ_STEP_EN
   assign advance = hold_done & step;
`else
   assign advance = hold_done;
`endif

   // Branching only ORs bits into the next-address field, so mpc wraps for free.
   always_comb begin
      next_raw = word[NA_LSB +: NA_W];
      next_raw[NA_W-1] = next_raw[NA_W-1] | (word[JAMZ_BIT] & flag_z)
                                          | (word[JAMN_BIT] & flag_n);
      if (word[JMPC_BIT]) begin
         next_raw[7:0] = next_raw[7:0] | mbr_byte;
      end
   end

   assign next_addr = ADDR_W'(next_raw);
   assign is_halt   = (next_addr == HALT_ADDR);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      mir      = '0;
      busy     = 1'b0;
      done     = 1'b0;
      cs_re    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = FETCH;
            end
         end
         FETCH: begin
            busy     = 1'b1;
            cs_re    = 1'b1;
            state_nx = EXEC;
         end
         EXEC: begin
            busy = 1'b1;
            mir  = word[MIR_W-1:0];
            if (advance) begin
               state_nx = is_halt ? DONE : FETCH;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nx = FETCH;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Hold counter saturates at the last hold cycle while waiting to advance.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mpc      <= START_ADDR;
         hold_cnt <= '0;
      end else begin
         if (idle_like && start) begin
            mpc <= START_ADDR;
         end else if ((state == EXEC) && advance && !is_halt) begin
            mpc <= next_addr;
         end

         if (state != EXEC) begin
            hold_cnt <= '0;
         end else if (!hold_done) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: a microprogram interpreter predicts the per-cycle
// outputs, compared on every falling edge, plus hand-computed literal checks.
module tb_micro_sequencer;

   localparam int LW = 1;

   typedef struct packed {
      logic [27:0] mir;
      logic [8:0]  mpc;
      logic        busy;
      logic        done;
   } obs_t;

   localparam logic [27:0] W0 = 28'b00_110001_00_0000_0000001000_0000;
   localparam logic [27:0] W1 = 28'b00_000000_10_0001_0000000101_0000;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        flag_n;
   logic        flag_z;
   logic [7:0]  mbr_byte;
   logic        cs_we;
   logic [8:0]  cs_waddr;
   logic [39:0] cs_wdata;
   logic [27:0] mir;
   logic [8:0]  mpc;
   logic        busy;
   logic        done;
`ifdef MICRO_SEQ_STEP_EN
   logic        step;
`endif

   int   checks;
   int   errors;
   bit   chk_en;
   obs_t exp_q[$];
   obs_t rest;
   logic [39:0] model_mem [512];

   micro_sequencer #(
      .ADDR_W    (9),
      .START_ADDR(9'h000),
      .HALT_ADDR (9'h1FF),
      .LONG_WAIT (LW)
   ) dut (
`ifdef MICRO_SEQ_STEP_EN
      .step    (step),
`endif
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .flag_n  (flag_n),
      .flag_z  (flag_z),
      .mbr_byte(mbr_byte),
      .cs_we   (cs_we),
      .cs_waddr(cs_waddr),
      .cs_wdata(cs_wdata),
      .mir     (mir),
      .mpc     (mpc),
      .busy    (busy),
      .done    (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Interprets the loaded microprogram from START_ADDR and queues the
   // outputs expected on each cycle after start is accepted.
   function automatic void build(input logic fn, input logic fz, input logic [7:0] mbr);
      logic [8:0]  pc;
      logic [8:0]  nxt;
      logic [39:0] w;
      int          hold;
      pc = 9'h000;
      exp_q.push_back('{mir: 28'd0, mpc: pc, busy: 1'b1, done: 1'b0});
      for (int n = 0; n < 64; n++) begin
         w    = model_mem[pc];
         hold = (w[18] || (w[13:4] != 10'd0)) ? 1 + LW : 1;
         for (int h = 0; h < hold; h++) begin
            exp_q.push_back('{mir: w[27:0], mpc: pc, busy: 1'b1, done: 1'b0});
         end
         nxt = w[39:31];
         if ((w[28] && fz) || (w[29] && fn)) nxt = nxt | 9'h100;
         if (w[30]) nxt = nxt | {1'b0, mbr};
         if (nxt == 9'h1FF) begin
            rest = '{mir: 28'd0, mpc: pc, busy: 1'b0, done: 1'b1};
            exp_q.push_back(rest);
            return;
         end
         pc = nxt;
         exp_q.push_back('{mir: 28'd0, mpc: pc, busy: 1'b1, done: 1'b0});
      end
   endfunction

   always @(negedge clock) begin
      obs_t e;
      if (chk_en) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = rest;
         chk("mir",  {12'd0, mir}, {12'd0, e.mir});
         chk("mpc",  {31'd0, mpc}, {31'd0, e.mpc});
         chk("busy", {39'd0, busy}, {39'd0, e.busy});
         chk("done", {39'd0, done}, {39'd0, e.done});
      end
   end

   task automatic write_word(input logic [8:0] a, input logic [39:0] d);
      @(posedge clock);
      #1 cs_we = 1'b1; cs_waddr = a; cs_wdata = d;
      model_mem[a] = d;
      @(posedge clock);
      #1 cs_we = 1'b0;
   endtask

   task automatic run(input logic fn, input logic fz, input logic [7:0] mbr,
                      input bit disturb, input bit lit);
      logic [27:0] lit_mir [7];
      lit_mir = '{28'd0, W0, W0, 28'd0, W1, W1, 28'd0};
      @(posedge clock);
      #1 flag_n = fn; flag_z = fz; mbr_byte = mbr; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      build(fn, fz, mbr);
      if (lit) begin
         for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            chk("lit_mir", {12'd0, mir}, {12'd0, lit_mir[i]});
         end
         chk("lit_busy", {39'd0, busy}, 40'd0);
         chk("lit_done", {39'd0, done}, 40'd1);
      end
      if (disturb) begin
         @(posedge clock);
         #1 cs_we = 1'b1; cs_waddr = 9'h000; cs_wdata = '1; start = 1'b1;
         @(posedge clock);
         #1 cs_we = 1'b0; start = 1'b0;
      end
      for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clock);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL run_timeout: %0d expected cycles left, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic load_prog1();
      write_word(9'h000, {9'h001, 3'b000, W0});
      write_word(9'h001, {9'h1FF, 3'b000, W1});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; chk_en = 1'b0;
      reset_n = 1'b0; start = 1'b0; flag_n = 1'b0; flag_z = 1'b0;
      mbr_byte = 8'h00; cs_we = 1'b0; cs_waddr = '0; cs_wdata = '0;
`ifdef MICRO_SEQ_STEP_EN
      step = 1'b1;
`endif
      for (int i = 0; i < 512; i++) model_mem[i] = '0;
      rest = '{mir: 28'd0, mpc: 9'h000, busy: 1'b0, done: 1'b0};

      repeat (2) @(posedge clock);
      #1;
      chk("rst_mir",  {12'd0, mir}, 40'd0);
      chk("rst_mpc",  {31'd0, mpc}, 40'd0);
      chk("rst_busy", {39'd0, busy}, 40'd0);
      chk("rst_done", {39'd0, done}, 40'd0);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // Two-word program: long word, then write word, then halt
      load_prog1();
      run(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("prog1_mpc", {31'd0, mpc}, 40'h001);

      // Store write and restart while busy must both be ignored
      run(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      run(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a hold
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      build(1'b0, 1'b0, 8'h00);
      @(posedge clock);
      #2;
      chk("pre_rst_mir", {12'd0, mir}, {12'd0, W0});
      chk_en = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("arst_mir",  {12'd0, mir}, 40'd0);
      chk("arst_busy", {39'd0, busy}, 40'd0);
      chk("arst_mpc",  {31'd0, mpc}, 40'd0);
      exp_q.delete();
      rest = '{mir: 28'd0, mpc: 9'h000, busy: 1'b0, done: 1'b0};
      @(posedge clock);
      #2 reset_n = 1'b1;
      chk_en = 1'b1;
      run(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // JAMZ branch, taken and not taken; JAMN bit clear ignores flag_n
      write_word(9'h000, {9'h010, 3'b001, 28'h0040001});
      write_word(9'h010, {9'h1FF, 3'b000, 28'h0000010});
      write_word(9'h110, {9'h1FF, 3'b000, 28'h0000110});
      run(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      chk("jamz_taken", {31'd0, mpc}, 40'h110);
      run(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("jamz_clear", {31'd0, mpc}, 40'h010);
      run(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("jamn_unset", {31'd0, mpc}, 40'h010);

      // JMPC dispatch on the MBR byte into a write-only word
      write_word(9'h000, {9'h000, 3'b100, 28'h0000003});
      write_word(9'h02A, {9'h1FF, 3'b000, 28'h0080000});
      run(1'b0, 1'b0, 8'h2A, 1'b0, 1'b0);
      chk("jmpc_mpc", {31'd0, mpc}, 40'h02A);

`ifdef MICRO_SEQ_STEP_EN
      load_prog1();
      chk_en = 1'b0;
      step = 1'b0;
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      chk("step_fetch", {12'd0, mir}, 40'd0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         chk("step_hold", {12'd0, mir}, {12'd0, W0});
      end
      @(posedge clock);
      #1 step = 1'b1;
      @(negedge clock);
      chk("step_cycle", {12'd0, mir}, {12'd0, W0});
      @(negedge clock);
      chk("step_adv", {12'd0, mir}, 40'd0);
      for (int i = 0; i < 50 && !done; i++) @(posedge clock);
      chk("step_done", {39'd0, done}, 40'd1);
      rest = '{mir: 28'd0, mpc: 9'h001, busy: 1'b0, done: 1'b1};
      chk_en = 1'b1;
`endif

      repeat (3) @(posedge clock);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
